display_mode_ctrl: RTL and testbench

Sequencer for the four-digit display multiplexer: drives its `displayState` select and owns the high-score digits it shows on the alternate setting. Tracks the best 4-digit BCD score across rounds and returns the display to the live count after a fixed hold time. On a new record, flashes the high-score view. Sits between the debounced button / game logic and the display mux; the mux and the 7-segment decoders are unchanged.

---
 rtl/display_pkg.sv | 21 ++
 rtl/display_mode_ctrl_cycle_timer.sv | 33 +++
 rtl/display_mode_ctrl.sv | 91 +++++++++
 tb/tb_display_mode_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the display-mode sequencer.
// No logic: states, digit geometry and the record comparison.
package display_pkg;

  typedef enum logic [1:0] {
    LIVE    = 2'd0,
    SHOW_HS = 2'd1,
    FLASH   = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 4;
  localparam int SCORE_W    = NUM_DIGITS * BCD_W;

  // Packed BCD orders the same as its decimal value, so a raw compare suffices.
  function automatic logic is_record(input logic [SCORE_W-1:0] score,
                                     input logic [SCORE_W-1:0] best);
    return score > best;
  endfunction

endpackage

// File: rtl/display_mode_ctrl_cycle_timer.sv
// Free-running cycle counter with a one-cycle done pulse at TERMINAL-1, then restart.
// done is combinational from the count register; no flow control.
module cycle_timer #(
  parameter int unsigned TERMINAL = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int unsigned CW = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;
  localparam logic [CW-1:0] LAST = CW'(TERMINAL - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign done = enable && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear)       count_d = '0;
    else if (done)   count_d = '0;
    else if (enable) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

endmodule

// File: rtl/display_mode_ctrl.sv
// Display select sequencer: live score / held high score / flashing new record.
// All outputs registered, 1-cycle latency; pulses consumed immediately, never queued.
module display_mode_ctrl
  import display_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 250000000,
  parameter int unsigned FLASH_CYCLES = 12500000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               show_req,
  input  logic               round_done,
  input  logic [SCORE_W-1:0] score,
  output logic               displayState,
  output logic [SCORE_W-1:0] hs_bcd,
  output logic               blank,
  output logic               new_record
);

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] hs_bcd_q, hs_bcd_d;
  logic               blank_q, blank_d;
  logic               new_record_q, new_record_d;
  logic               disp_q;
  logic               record;
  logic               hold_done, flash_done;
  logic               hold_clear, flash_clear;

  assign record = round_done && is_record(score, hs_bcd_q);

  // A record re-enters FLASH even from FLASH, so it restarts both timers.
  assign hold_clear  = record || (state_d != state_q);
  assign flash_clear = record || (state_q != FLASH);

  cycle_timer #(.TERMINAL(HOLD_CYCLES)) u_hold (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (hold_clear),
    .enable  (state_q != LIVE),
    .done    (hold_done)
  );

  cycle_timer #(.TERMINAL(FLASH_CYCLES)) u_flash (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flash_clear),
    .enable  (state_q == FLASH),
    .done    (flash_done)
  );

  always_comb begin
    state_d      = state_q;
    hs_bcd_d     = hs_bcd_q;
    new_record_d = new_record_q;
    if (record) begin
      state_d      = FLASH;
      hs_bcd_d     = score;
      new_record_d = 1'b1;
    end else begin
      if (round_done) new_record_d = 1'b0;
      if (show_req)       state_d = (state_q == LIVE) ? SHOW_HS : LIVE;
      else if (hold_done) state_d = LIVE;
    end

    blank_d = blank_q;
    if (state_d != FLASH || record) blank_d = 1'b0;
    else if (flash_done)            blank_d = ~blank_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= LIVE;
      hs_bcd_q     <= '0;
      blank_q      <= 1'b0;
      new_record_q <= 1'b0;
      disp_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hs_bcd_q     <= hs_bcd_d;
      blank_q      <= blank_d;
      new_record_q <= new_record_d;
      disp_q       <= (state_d != LIVE);
    end
  end

  assign displayState = disp_q;
  assign hs_bcd       = hs_bcd_q;
  assign blank        = blank_q;
  assign new_record   = new_record_q;

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Directed bench for display_mode_ctrl with HOLD_CYCLES=8, FLASH_CYCLES=2.
module tb_display_mode_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        show_req;
  logic        round_done;
  logic [15:0] score;
  logic        displayState;
  logic [15:0] hs_bcd;
  logic        blank;
  logic        new_record;

  int n_checks = 0;
  int n_errors = 0;

  // Blank level after the k-th edge of an 8-cycle flash hold (bit k).
  logic [7:0] blank_pat = 8'b11001100;

  display_mode_ctrl #(.HOLD_CYCLES(8), .FLASH_CYCLES(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .show_req     (show_req),
    .round_done   (round_done),
    .score        (score),
    .displayState (displayState),
    .hs_bcd       (hs_bcd),
    .blank        (blank),
    .new_record   (new_record)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic shw, input logic rd, input logic [15:0] sc);
    show_req   = shw;
    round_done = rd;
    score      = sc;
    tick();
    show_req   = 1'b0;
    round_done = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; show_req = 1'b0; round_done = 1'b0; score = 16'h0000;
    tick(); tick();
    chk("rst_disp", {15'd0, displayState}, 16'd0);
    chk("rst_hs", hs_bcd, 16'h0000);
    chk("rst_blank", {15'd0, blank}, 16'd0);
    chk("rst_nrec", {15'd0, new_record}, 16'd0);
    reset_n = 1'b1;
    tick();

    // Show then timeout exactly 8 cycles after entry
    pulse(1'b1, 1'b0, 16'h0000);
    chk("show_entry", {15'd0, displayState}, 16'd1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("show_hold%0d", i), {15'd0, displayState}, (i < 8) ? 16'd1 : 16'd0);
    end

    // Second show_req at cycle 3 aborts
    pulse(1'b1, 1'b0, 16'h0000);
    tick(); tick();
    chk("show_pre_abort", {15'd0, displayState}, 16'd1);
    pulse(1'b1, 1'b0, 16'h0000);
    chk("show_abort", {15'd0, displayState}, 16'd0);

    // First record and the blink pattern
    pulse(1'b0, 1'b1, 16'h0123);
    chk("rec1_hs", hs_bcd, 16'h0123);
    chk("rec1_nrec", {15'd0, new_record}, 16'd1);
    chk("rec1_disp", {15'd0, displayState}, 16'd1);
    chk("rec1_blank0", {15'd0, blank}, 16'd0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("rec1_blank%0d", i), {15'd0, blank}, {15'd0, blank_pat[i]});
      chk($sformatf("rec1_disp%0d", i), {15'd0, displayState}, 16'd1);
    end
    tick();
    chk("rec1_exit_disp", {15'd0, displayState}, 16'd0);
    chk("rec1_exit_blank", {15'd0, blank}, 16'd0);
    chk("rec1_exit_nrec", {15'd0, new_record}, 16'd1);

    // Equal and lower scores are not records
    pulse(1'b0, 1'b1, 16'h0123);
    chk("eq_hs", hs_bcd, 16'h0123);
    chk("eq_nrec", {15'd0, new_record}, 16'd0);
    chk("eq_disp", {15'd0, displayState}, 16'd0);
    pulse(1'b0, 1'b1, 16'h0099);
    chk("lo_hs", hs_bcd, 16'h0123);
    chk("lo_nrec", {15'd0, new_record}, 16'd0);
    chk("lo_disp", {15'd0, displayState}, 16'd0);

    // Simultaneous pulses, record wins -> FLASH
    pulse(1'b1, 1'b1, 16'h0500);
    chk("sim_rec_hs", hs_bcd, 16'h0500);
    chk("sim_rec_disp", {15'd0, displayState}, 16'd1);
    chk("sim_rec_nrec", {15'd0, new_record}, 16'd1);
    tick(); tick();
    chk("sim_rec_blank", {15'd0, blank}, 16'd1);
    pulse(1'b1, 1'b0, 16'h0000);
    chk("flash_abort_disp", {15'd0, displayState}, 16'd0);
    chk("flash_abort_blank", {15'd0, blank}, 16'd0);
    chk("flash_abort_nrec", {15'd0, new_record}, 16'd1);

    // Simultaneous pulses, non-record -> SHOW_HS
    pulse(1'b1, 1'b1, 16'h0001);
    chk("sim_nrec_hs", hs_bcd, 16'h0500);
    chk("sim_nrec_disp", {15'd0, displayState}, 16'd1);
    chk("sim_nrec_nrec", {15'd0, new_record}, 16'd0);
    tick(); tick();
    chk("sim_nrec_blank", {15'd0, blank}, 16'd0);
    pulse(1'b1, 1'b0, 16'h0000);
    chk("sim_nrec_exit", {15'd0, displayState}, 16'd0);

    // Further record during FLASH restarts both timers
    pulse(1'b0, 1'b1, 16'h0600);
    tick(); tick(); tick();
    chk("rerec_pre_blank", {15'd0, blank}, 16'd1);
    pulse(1'b0, 1'b1, 16'h0700);
    chk("rerec_hs", hs_bcd, 16'h0700);
    chk("rerec_blank0", {15'd0, blank}, 16'd0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("rerec_disp%0d", i), {15'd0, displayState}, (i < 8) ? 16'd1 : 16'd0);
      if (i < 8)
        chk($sformatf("rerec_blank%0d", i), {15'd0, blank}, {15'd0, blank_pat[i]});
    end

    // Asynchronous reset mid-flash
    pulse(1'b0, 1'b1, 16'h0800);
    tick(); tick(); tick(); tick();
    chk("mid_pre_disp", {15'd0, displayState}, 16'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_disp", {15'd0, displayState}, 16'd0);
    chk("mid_rst_hs", hs_bcd, 16'h0000);
    chk("mid_rst_blank", {15'd0, blank}, 16'd0);
    chk("mid_rst_nrec", {15'd0, new_record}, 16'd0);
    tick();
    reset_n = 1'b1;
    tick(); tick();
    chk("post_rst_disp", {15'd0, displayState}, 16'd0);
    chk("post_rst_hs", hs_bcd, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
